pipe_stage_reg: RTL and testbench

- Generalised inter-stage pipeline register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB instances).
- Carries a parametrised data payload plus a control-bit field, with a valid/ready handshake and a synchronous flush.
- SKID=1 adds a second entry so upstream ready is fully registered.
- Invalid (bubble) entries always present all-zero control, so downstream never sees a spurious RegWrite or MEM_WEN.

---
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional second (skid) entry that makes in_ready purely registered.
module pipe_stage_reg #(
   parameter int PAYLOAD_W = 101,
   parameter int CTRL_W    = 4,
   parameter int SKID      = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [CTRL_W-1:0]    in_ctrl,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CTRL_W-1:0]    out_ctrl,
   output logic [1:0]           occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [PAYLOAD_W-1:0] main_payload_reg, skid_payload_reg;
   logic [CTRL_W-1:0]    main_ctrl_reg, skid_ctrl_reg;

   logic main_valid, skid_valid;
   logic accept, emit;
   logic load_main_in, load_skid_in, move_skid, clear_ctrl;

   assign main_valid = (state_reg != ST_EMPTY);
   assign skid_valid = (state_reg == ST_FULL);

   generate
      if (SKID != 0) begin : g_skid_ready
         assign in_ready = ~skid_valid;
      end else begin : g_comb_ready
         assign in_ready = ~main_valid | out_ready;
      end
   endgenerate

   assign accept = in_valid & in_ready;
   assign emit   = main_valid & out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      load_main_in = 1'b0;
      load_skid_in = 1'b0;
      move_skid    = 1'b0;
      clear_ctrl   = 1'b0;
      if (flush) begin
         // The flush-cycle input is dropped; a coincident emit has already
         // been seen downstream, so ending empty is all that is needed.
         state_next = ST_EMPTY;
         clear_ctrl = 1'b1;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (accept) begin
                  load_main_in = 1'b1;
                  state_next   = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  if (SKID != 0) begin
                     load_skid_in = 1'b1;
                     state_next   = ST_FULL;
                  end
               end else if (emit) begin
                  state_next = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  move_skid  = 1'b1;
                  state_next = ST_ONE;
               end
            end
            default: begin
               state_next = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         main_payload_reg <= '0;
         main_ctrl_reg    <= '0;
         skid_payload_reg <= '0;
         skid_ctrl_reg    <= '0;
      end else if (clear_ctrl) begin
         main_ctrl_reg <= '0;
         skid_ctrl_reg <= '0;
      end else begin
         if (load_main_in) begin
            main_payload_reg <= in_payload;
            main_ctrl_reg    <= in_ctrl;
         end else if (move_skid) begin
            main_payload_reg <= skid_payload_reg;
            main_ctrl_reg    <= skid_ctrl_reg;
         end
         if (load_skid_in) begin
            skid_payload_reg <= in_payload;
            skid_ctrl_reg    <= in_ctrl;
         end
      end
   end

   assign out_valid   = main_valid;
   assign out_payload = main_payload_reg;
   assign out_ctrl    = main_valid ? main_ctrl_reg : '0;
   assign occupancy   = state_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a FIFO-level model checks both a SKID=0 and a
// SKID=1 instance every cycle; directed scenarios add literal expectations.
module tb_pipe_stage_reg;
   localparam int PW = 101;
   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          flush      [2];
   logic          in_valid   [2];
   logic          in_ready   [2];
   logic [PW-1:0] in_payload [2];
   logic [CW-1:0] in_ctrl    [2];
   logic          out_valid  [2];
   logic          out_ready  [2];
   logic [PW-1:0] out_payload[2];
   logic [CW-1:0] out_ctrl   [2];
   logic [1:0]    occupancy  [2];

   int checks = 0;
   int errors = 0;

   // model: entries in FIFO order, index 0 is the head
   int            m_cnt [2];
   logic [PW-1:0] m_pl  [2][2];
   logic [CW-1:0] m_ct  [2][2];
   int            log0[$];
   int            log1[$];

   always #5 clock = ~clock;

   pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(0)) u_dut0 (
      .clock(clock), .reset(reset), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_payload(in_payload[0]), .in_ctrl(in_ctrl[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_payload(out_payload[0]), .out_ctrl(out_ctrl[0]),
      .occupancy(occupancy[0]));

   pipe_stage_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SKID(1)) u_dut1 (
      .clock(clock), .reset(reset), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_payload(in_payload[1]), .in_ctrl(in_ctrl[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_payload(out_payload[1]), .out_ctrl(out_ctrl[1]),
      .occupancy(occupancy[1]));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // compare process: check, then advance the model by one clock
   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         logic exp_rdy, acc, em;
         if (reset) begin
            m_cnt[k] = 0;
            check($sformatf("rst_payload%0d", k), 128'(out_payload[k]), 128'd0);
         end
         exp_rdy = (k == 1) ? (m_cnt[k] < 2) : (m_cnt[k] == 0 || out_ready[k]);
         check($sformatf("valid%0d", k), 128'(out_valid[k]), 128'(m_cnt[k] > 0));
         check($sformatf("ready%0d", k), 128'(in_ready[k]), 128'(exp_rdy));
         check($sformatf("occ%0d", k), 128'(occupancy[k]), 128'(m_cnt[k]));
         check($sformatf("ctrl%0d", k), 128'(out_ctrl[k]),
               (m_cnt[k] > 0) ? 128'(m_ct[k][0]) : 128'd0);
         if (m_cnt[k] > 0)
            check($sformatf("payload%0d", k), 128'(out_payload[k]), 128'(m_pl[k][0]));
         if (!reset) begin
            acc = in_valid[k] && exp_rdy;
            em  = (m_cnt[k] > 0) && out_ready[k];
            if (em) begin
               if (k == 0) log0.push_back(int'(out_payload[k][31:0]));
               else        log1.push_back(int'(out_payload[k][31:0]));
            end
            if (flush[k]) begin
               m_cnt[k] = 0;
            end else begin
               if (em) begin
                  m_pl[k][0] = m_pl[k][1];
                  m_ct[k][0] = m_ct[k][1];
                  m_cnt[k]--;
               end
               if (acc) begin
                  m_pl[k][m_cnt[k]] = in_payload[k];
                  m_ct[k][m_cnt[k]] = in_ctrl[k];
                  m_cnt[k]++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send1(input int p, input logic [3:0] c);
      in_valid[1] = 1'b1; in_payload[1] = PW'(p); in_ctrl[1] = c;
      tick();
      in_valid[1] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         flush[k] = 0; in_valid[k] = 0; in_payload[k] = '0;
         in_ctrl[k] = '0; out_ready[k] = 0; m_cnt[k] = 0;
      end
      tick(); tick();
      reset = 1'b0;
      #1;
      check("ready_after_rst", 128'(in_ready[1]), 128'd1);

      // streaming 1..10 with 1-cycle latency
      out_ready[1] = 1'b1;
      log1.delete();
      for (int i = 1; i <= 10; i++) begin
         in_valid[1] = 1'b1; in_payload[1] = PW'(i); in_ctrl[1] = 4'(i);
         tick();
         check("stream_pl", 128'(out_payload[1]), 128'(i));
         check("stream_occ", 128'(occupancy[1]), 128'd1);
         check("stream_rdy", 128'(in_ready[1]), 128'd1);
      end
      in_valid[1] = 1'b0;
      tick(); tick();
      check("stream_cnt", 128'(log1.size()), 128'd10);
      for (int i = 0; i < log1.size() && i < 10; i++)
         check("stream_order", 128'(log1[i]), 128'(i + 1));

      // backpressure
      log1.delete();
      out_ready[1] = 1'b0;
      send1(32'h11, 4'h1);
      send1(32'h22, 4'h2);
      in_valid[1] = 1'b1; in_payload[1] = PW'(32'h33); in_ctrl[1] = 4'h3;
      check("bp_occ", 128'(occupancy[1]), 128'd2);
      check("bp_rdy", 128'(in_ready[1]), 128'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_stable_pl", 128'(out_payload[1]), 128'h11);
         check("bp_stable_ctrl", 128'(out_ctrl[1]), 128'h1);
      end
      out_ready[1] = 1'b1;
      for (int i = 0; i < 10 && in_valid[1]; i++) begin
         logic was_rdy;
         was_rdy = in_ready[1];
         tick();
         if (was_rdy) in_valid[1] = 1'b0;
      end
      check("bp_accepted", 128'(in_valid[1]), 128'd0);
      tick(); tick(); tick();
      check("bp_cnt", 128'(log1.size()), 128'd3);
      if (log1.size() == 3) begin
         check("bp_ord0", 128'(log1[0]), 128'h11);
         check("bp_ord1", 128'(log1[1]), 128'h22);
         check("bp_ord2", 128'(log1[2]), 128'h33);
      end

      // flush while full
      log1.delete();
      out_ready[1] = 1'b0;
      send1(32'hA1, 4'hF);
      send1(32'hA2, 4'hF);
      check("fl_occ_pre", 128'(occupancy[1]), 128'd2);
      flush[1] = 1'b1;
      in_valid[1] = 1'b1; in_payload[1] = PW'(32'hA3); in_ctrl[1] = 4'hF;
      tick();
      flush[1] = 1'b0; in_valid[1] = 1'b0;
      check("fl_valid", 128'(out_valid[1]), 128'd0);
      check("fl_ctrl", 128'(out_ctrl[1]), 128'd0);
      check("fl_occ", 128'(occupancy[1]), 128'd0);
      out_ready[1] = 1'b1;
      tick(); tick(); tick();
      check("fl_nothing_out", 128'(log1.size()), 128'd0);

      // bubble gating
      in_valid[1] = 1'b0; in_ctrl[1] = 4'hF; in_payload[1] = PW'(32'hDEAD);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bub_ctrl", 128'(out_ctrl[1]), 128'd0);
         check("bub_valid", 128'(out_valid[1]), 128'd0);
      end

      // asynchronous reset while full
      out_ready[1] = 1'b0;
      send1(32'hAAAA, 4'h5);
      send1(32'hBBBB, 4'h6);
      check("rst_pre_occ", 128'(occupancy[1]), 128'd2);
      #2 reset = 1'b1;
      #1;
      check("rst_valid", 128'(out_valid[1]), 128'd0);
      check("rst_ctrl", 128'(out_ctrl[1]), 128'd0);
      check("rst_pl", 128'(out_payload[1]), 128'd0);
      check("rst_occ", 128'(occupancy[1]), 128'd0);
      tick();
      reset = 1'b0;
      #1;
      check("rst_rdy", 128'(in_ready[1]), 128'd1);

      // SKID=0: combinational ready, accept and emit in one cycle
      log0.delete();
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b1; in_payload[0] = PW'(32'h5); in_ctrl[0] = 4'h9;
      tick();
      in_payload[0] = PW'(32'h6); in_ctrl[0] = 4'hA;
      check("s0_full_rdy", 128'(in_ready[0]), 128'd0);
      check("s0_occ", 128'(occupancy[0]), 128'd1);
      tick();
      check("s0_hold_pl", 128'(out_payload[0]), 128'h5);
      out_ready[0] = 1'b1;
      #1;
      check("s0_comb_rdy", 128'(in_ready[0]), 128'd1);
      tick();
      in_valid[0] = 1'b0;
      check("s0_new_pl", 128'(out_payload[0]), 128'h6);
      check("s0_occ2", 128'(occupancy[0]), 128'd1);
      check("s0_emitted", 128'(log0.size()), 128'd1);
      tick(); tick();
      check("s0_cnt", 128'(log0.size()), 128'd2);
      if (log0.size() == 2) check("s0_ord", 128'(log0[1]), 128'h6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
